// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and helpers for the pipeline sequencing controller and its
// hazard comparator.
//   pipe_state_e  : controller FSM state, encoded to match state_o
//   stage_ctrl_s  : the six per-stage write/flush strobes as one bundle
//   ctrl_*()      : canned strobe patterns for each pipeline situation
//   sat_inc32()   : saturating increment used by the optional perf counters
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W_DEFAULT = 5;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        ERROR    = 2'd3
    } pipe_state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_write;
        logic memwb_flush;
    } stage_ctrl_s;

    // Drain pattern: nothing advances, every clearable stage is cleared.
    function automatic stage_ctrl_s ctrl_init();
        stage_ctrl_s c;
        c = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
              idex_flush: 1'b1, exmem_write: 1'b0, memwb_flush: 1'b1};
        return c;
    endfunction

    // Normal flow: every stage loads, nothing is cleared.
    function automatic stage_ctrl_s ctrl_run();
        stage_ctrl_s c;
        c = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
              idex_flush: 1'b0, exmem_write: 1'b1, memwb_flush: 1'b0};
        return c;
    endfunction

    // Memory freeze: front of the pipe holds, a bubble drains into WB.
    function automatic stage_ctrl_s ctrl_mem_freeze();
        stage_ctrl_s c;
        c = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
              idex_flush: 1'b0, exmem_write: 1'b0, memwb_flush: 1'b1};
        return c;
    endfunction

    // Taken branch: squash the two younger instructions, redirect the PC.
    function automatic stage_ctrl_s ctrl_branch();
        stage_ctrl_s c;
        c = ctrl_run();
        c.ifid_flush = 1'b1;
        c.idex_flush = 1'b1;
        return c;
    endfunction

    // Load-use: hold PC and IF/ID, push a bubble into ID/EX.
    function automatic stage_ctrl_s ctrl_bubble();
        stage_ctrl_s c;
        c = ctrl_run();
        c.pc_write   = 1'b0;
        c.ifid_write = 1'b0;
        c.idex_flush = 1'b1;
        return c;
    endfunction

    // Fatal stop: everything frozen, nothing cleared, so state can be inspected.
    function automatic stage_ctrl_s ctrl_halt();
        stage_ctrl_s c;
        c = '0;
        return c;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use comparator. Flags when the instruction in EX
// is a load whose destination is read by the instruction in ID. Register 0 is
// hard-wired zero, so a load to x0 never creates a dependency.
//   ex_MemRead  : EX instruction is a load
//   ex_rd       : EX destination register
//   id_rs1      : ID source register 1 (always read)
//   id_rs2      : ID source register 2
//   id_uses_rs2 : ID instruction actually reads rs2
//   load_use    : one-bubble stall required
// ---------------------------------------------------------------------------
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
    input  logic                  ex_MemRead,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs2,
    output logic                  load_use
);

    logic rs1_match;
    logic rs2_match;

    always_comb begin
        rs1_match = (ex_rd == id_rs1);
        rs2_match = id_uses_rs2 && (ex_rd == id_rs2);
        load_use  = ex_MemRead && (ex_rd != '0) && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central sequencing controller for the 5-stage pipeline. Produces the
// per-stage write-enable and flush strobes, resolving load-use bubbles,
// taken-branch flushes and multi-cycle data-memory freezes with a timeout.
// After reset the pipe is drained for INIT_CYCLES cycles.
//   clk, reset         : rising-edge clock, async active-low reset
//   id_*/ex_*          : operand/destination info for load-use detection
//   branch_taken       : EX resolved a taken branch/jump
//   mem_req/mem_ready  : data-memory access handshake in MEM
//   pc_write ... memwb_flush : stage strobes (combinational, same-cycle)
//   mem_timeout_err    : sticky memory timeout flag
//   state_o            : INIT=0, RUN=1, MEM_WAIT=2, ERROR=3
// Optional build macro PIPE_HAZARD_PERF_EN adds saturating counters
// stall_cycles, bubble_count and flush_count.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int INIT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int REG_ADDR_W  = REG_ADDR_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs2,
    input  logic                  ex_MemRead,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_write,
    output logic                  memwb_flush,
    output logic                  mem_timeout_err,
    output logic [1:0]            state_o
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           bubble_count,
    output logic [31:0]           flush_count
`endif
);

    localparam logic [3:0] INIT_LOAD = 4'(INIT_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    pipe_state_e state_q, state_d;
    logic [3:0]  init_cnt_q, init_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;

    logic        load_use;
    logic        mem_stall;
    stage_ctrl_s resolve_ctrl;
    stage_ctrl_s ctrl;
    logic        bubble_evt;
    logic        flush_evt;
    logic        stall_evt;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .ex_MemRead  (ex_MemRead),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs2 (id_uses_rs2),
        .load_use    (load_use)
    );

    // Branch-over-load-use resolution, shared by RUN and the cycle a memory
    // access completes. A branch flushes ID, so its load-use is moot.
    always_comb begin
        mem_stall = mem_req && !mem_ready;
        if (branch_taken) begin
            resolve_ctrl = ctrl_branch();
        end else if (load_use) begin
            resolve_ctrl = ctrl_bubble();
        end else begin
            resolve_ctrl = ctrl_run();
        end
    end

    // Next-state and strobe decode. The memory freeze outranks everything:
    // EX is held during it, so branch/load-use simply re-evaluate afterwards.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        ctrl       = ctrl_run();
        bubble_evt = 1'b0;
        flush_evt  = 1'b0;
        stall_evt  = 1'b0;

        case (state_q)
            INIT: begin
                ctrl = ctrl_init();
                if (init_cnt_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    init_cnt_d = init_cnt_q - 4'd1;
                end
            end

            RUN: begin
                if (mem_stall) begin
                    ctrl       = ctrl_mem_freeze();
                    wait_cnt_d = 8'd1;
                    state_d    = MEM_WAIT;
                end else begin
                    ctrl       = resolve_ctrl;
                    flush_evt  = branch_taken;
                    bubble_evt = !branch_taken && load_use;
                end
                stall_evt = !ctrl.pc_write;
            end

            MEM_WAIT: begin
                if (mem_stall) begin
                    ctrl = ctrl_mem_freeze();
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else begin
                    ctrl       = resolve_ctrl;
                    flush_evt  = branch_taken;
                    bubble_evt = !branch_taken && load_use;
                    wait_cnt_d = 8'd0;
                    state_d    = RUN;
                end
                stall_evt = !ctrl.pc_write;
            end

            ERROR: begin
                ctrl  = ctrl_halt();
                err_d = 1'b1;
            end

            default: begin
                ctrl    = ctrl_init();
                state_d = INIT;
            end
        endcase
    end

    // Controller state; reset re-arms the drain sequence and clears the error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= INIT;
            init_cnt_q <= INIT_LOAD;
            wait_cnt_q <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        pc_write        = ctrl.pc_write;
        ifid_write      = ctrl.ifid_write;
        ifid_flush      = ctrl.ifid_flush;
        idex_flush      = ctrl.idex_flush;
        exmem_write     = ctrl.exmem_write;
        memwb_flush     = ctrl.memwb_flush;
        mem_timeout_err = err_q;
        state_o         = state_q;
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] bubble_count_q, bubble_count_d;
    logic [31:0] flush_count_q,  flush_count_d;

    // Event flags are only raised in RUN/MEM_WAIT, so INIT and ERROR
    // cycles never reach the counters.
    always_comb begin
        stall_cycles_d = stall_evt  ? sat_inc32(stall_cycles_q) : stall_cycles_q;
        bubble_count_d = bubble_evt ? sat_inc32(bubble_count_q) : bubble_count_q;
        flush_count_d  = flush_evt  ? sat_inc32(flush_count_q)  : flush_count_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= 32'd0;
            bubble_count_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            bubble_count_q <= bubble_count_d;
            flush_count_q  <= flush_count_d;
        end
    end

    always_comb begin
        stall_cycles = stall_cycles_q;
        bubble_count = bubble_count_q;
        flush_count  = flush_count_q;
    end
`else
    logic perf_unused;
    always_comb begin
        perf_unused = bubble_evt ^ flush_evt ^ stall_evt;
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed-vector bench for pipe_hazard_ctrl with INIT_CYCLES=4 and
// MEM_TIMEOUT=16. Strobes are compared as one 6-bit word ordered
// {pc_write, ifid_write, ifid_flush, idex_flush, exmem_write, memwb_flush}.
// Perf counters are checked when PIPE_HAZARD_PERF_EN is defined.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam logic [5:0] S_INIT   = 6'b001101;
    localparam logic [5:0] S_RUN    = 6'b110010;
    localparam logic [5:0] S_BUBBLE = 6'b000110;
    localparam logic [5:0] S_BRANCH = 6'b111110;
    localparam logic [5:0] S_FREEZE = 6'b000001;
    localparam logic [5:0] S_HALT   = 6'b000000;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs2;
    logic       ex_MemRead;
    logic [4:0] ex_rd;
    logic       branch_taken;
    logic       mem_req;
    logic       mem_ready;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_write;
    logic       memwb_flush;
    logic       mem_timeout_err;
    logic [1:0] state_o;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] bubble_count;
    logic [31:0] flush_count;
`endif

    int testsRun;
    int testsFailed;

    pipe_hazard_ctrl #(
        .INIT_CYCLES (4),
        .MEM_TIMEOUT (16),
        .REG_ADDR_W  (5)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs2     (id_uses_rs2),
        .ex_MemRead      (ex_MemRead),
        .ex_rd           (ex_rd),
        .branch_taken    (branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .exmem_write     (exmem_write),
        .memwb_flush     (memwb_flush),
        .mem_timeout_err (mem_timeout_err),
        .state_o         (state_o)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .bubble_count    (bubble_count),
        .flush_count     (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one input vector and let the combinational strobes settle.
    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic uses2, input logic memread,
                                 input logic [4:0] rd, input logic br,
                                 input logic req, input logic rdy);
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_uses_rs2  = uses2;
        ex_MemRead   = memread;
        ex_rd        = rd;
        branch_taken = br;
        mem_req      = req;
        mem_ready    = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] strobes();
        return {pc_write, ifid_write, ifid_flush, idex_flush, exmem_write, memwb_flush};
    endfunction

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b0;
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Reset held: INIT pattern, no error
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_strobes", 32'(strobes()), 32'(S_INIT));
        checkOutput("reset_state", 32'(state_o), 32'd0);
        checkOutput("reset_err", 32'(mem_timeout_err), 32'd0);

        // Drain: exactly four INIT cycles after release
        reset = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("init_state_%0d", i), 32'(state_o), 32'd0);
            checkOutput($sformatf("init_strobes_%0d", i), 32'(strobes()), 32'(S_INIT));
            tick();
        end
        checkOutput("run_state", 32'(state_o), 32'd1);
        checkOutput("run_strobes", 32'(strobes()), 32'(S_RUN));

        // Load-use on rs1: one bubble, then clears
        applyStimulus(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_rs1", 32'(strobes()), 32'(S_BUBBLE));
        tick();
        applyStimulus(5'd5, 5'd0, 1'b0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_cleared", 32'(strobes()), 32'(S_RUN));
        checkOutput("lu_state", 32'(state_o), 32'd1);

        // Load to x0 never stalls
        applyStimulus(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_x0", 32'(strobes()), 32'(S_RUN));

        // rs2 match only matters when rs2 is read
        applyStimulus(5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_rs2_unused", 32'(strobes()), 32'(S_RUN));
        applyStimulus(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_rs2_used", 32'(strobes()), 32'(S_BUBBLE));
        tick();

        // Non-load EX with matching rd: no stall
        applyStimulus(5'd9, 5'd0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
        checkOutput("no_load", 32'(strobes()), 32'(S_RUN));

        // Branch overrides a simultaneous load-use
        applyStimulus(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        checkOutput("branch_over_lu", 32'(strobes()), 32'(S_BRANCH));
        tick();

        // Memory access: 3 frozen cycles, branch ignored while frozen
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        checkOutput("mem_freeze_0", 32'(strobes()), 32'(S_FREEZE));
        checkOutput("mem_state_0", 32'(state_o), 32'd1);
        tick();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < 3; i++) begin
            checkOutput($sformatf("mem_freeze_%0d", i), 32'(strobes()), 32'(S_FREEZE));
            checkOutput($sformatf("mem_state_%0d", i), 32'(state_o), 32'd2);
            tick();
        end
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("mem_ready_strobes", 32'(strobes()), 32'(S_RUN));
        checkOutput("mem_ready_state", 32'(state_o), 32'd2);
        tick();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("mem_back_run", 32'(state_o), 32'd1);

`ifdef PIPE_HAZARD_PERF_EN
        checkOutput("perf_bubbles", bubble_count, 32'd2);
        checkOutput("perf_flushes", flush_count, 32'd1);
        checkOutput("perf_stalls", stall_cycles, 32'd5);
`endif

        // mem_ready without mem_req in RUN is ignored
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("stray_ready", 32'(strobes()), 32'(S_RUN));
        tick();
        checkOutput("stray_ready_state", 32'(state_o), 32'd1);

        // Access abandoned (mem_req drops): load-use honoured on exit
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
        checkOutput("drop_req_state", 32'(state_o), 32'd2);
        checkOutput("drop_req_lu", 32'(strobes()), 32'(S_BUBBLE));
        tick();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("drop_req_run", 32'(state_o), 32'd1);

        // Timeout: 16 frozen cycles, then sticky ERROR
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("to_freeze_%0d", i), 32'(strobes()), 32'(S_FREEZE));
            checkOutput($sformatf("to_err_%0d", i), 32'(mem_timeout_err), 32'd0);
            tick();
        end
        checkOutput("to_state", 32'(state_o), 32'd3);
        checkOutput("to_err", 32'(mem_timeout_err), 32'd1);
        checkOutput("to_halt", 32'(strobes()), 32'(S_HALT));
        applyStimulus(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("err_hold_state", 32'(state_o), 32'd3);
        checkOutput("err_hold_flag", 32'(mem_timeout_err), 32'd1);
        checkOutput("err_hold_halt", 32'(strobes()), 32'(S_HALT));

        // Reset out of ERROR returns to INIT and clears the flag
        reset = 1'b0;
        #1;
        checkOutput("rst_err_state", 32'(state_o), 32'd0);
        checkOutput("rst_err_flag", 32'(mem_timeout_err), 32'd0);
        checkOutput("rst_err_strobes", 32'(strobes()), 32'(S_INIT));
`ifdef PIPE_HAZARD_PERF_EN
        checkOutput("rst_perf_stalls", stall_cycles, 32'd0);
`endif
        tick();
        reset = 1'b1;
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        checkOutput("rerun_state", 32'(state_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage 64-bit pipeline. It produces the per-stage write-enable and flush strobes for the PC, IF/ID, ID/EX, EX_MEM and MEM/WB registers. It resolves three conditions:
- load-use hazards, by inserting one bubble;
- taken branches resolved in EX, by flushing two stages;
- multi-cycle data-memory accesses, by freezing the pipe under a ready handshake with a timeout.

After reset it runs a pipeline-drain sequence.

Parameters:
INIT_CYCLES, 4, cycles of full flush after reset (1..15)
MEM_TIMEOUT, 16, max MEM_WAIT cycles before error (2..255)
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
id_rs1  in  REG_ADDR_W  source reg 1 of instruction in ID
id_rs2  in  REG_ADDR_W  source reg 2 of instruction in ID
id_uses_rs2  in  1  ID instruction reads rs2
ex_MemRead  in  1  instruction in EX is a load
ex_rd  in  REG_ADDR_W  destination of instruction in EX
branch_taken  in  1  EX resolved a taken branch/jump
mem_req  in  1  MEM stage issues a data-memory access (load or MemWrite)
mem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID clear (overrides write)
idex_flush  out  1  ID/EX clear (inserts bubble)
exmem_write  out  1  EX_MEM load enable
memwb_flush  out  1  MEM/WB clear
mem_timeout_err  out  1  sticky timeout flag
state_o  out  2  current FSM state (INIT=0, RUN=1, MEM_WAIT=2, ERROR=3)

Behaviour:
- Registers: state, init_cnt, wait_cnt, err flag. Stage strobes are combinational decode of state plus inputs, so a stall takes effect in the same cycle.
- Reset (reset=0, async): state=INIT, init_cnt=INIT_CYCLES-1, wait_cnt=0, mem_timeout_err=0.
- Outputs while in reset or INIT: pc_write=0, ifid_write=0, exmem_write=0, ifid_flush=1, idex_flush=1, memwb_flush=1.
- INIT: init_cnt decrements each cycle. At 0 the next state is RUN. INIT lasts exactly INIT_CYCLES cycles after reset release.
- RUN default outputs: all writes=1, all flushes=0.
  - Priority 1, memory stall: mem_req & !mem_ready.
    - pc_write=ifid_write=exmem_write=0, idex_flush=0, memwb_flush=1.
    - wait_cnt<=1; next MEM_WAIT.
    - branch_taken and load-use are ignored this cycle; EX is held, so they re-evaluate later.
  - Priority 2, taken branch: branch_taken.
    - ifid_flush=1, idex_flush=1, pc_write=1.
    - Load-use is ignored, because the ID instruction is flushed.
  - Priority 3, load-use: ex_MemRead & ex_rd!=0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
    - pc_write=0, ifid_write=0, idex_flush=1.
    - Exactly one bubble; the hazard self-clears next cycle.
- MEM_WAIT:
  - While mem_req & !mem_ready: same freeze outputs as the RUN memory stall; wait_cnt increments.
  - If wait_cnt==MEM_TIMEOUT-1 and still not ready: next ERROR, mem_timeout_err<=1.
  - mem_ready=1, or mem_req dropped: the access completes. Outputs are evaluated exactly as RUN priorities 2–3 (branch/load-use honored); next RUN; wait_cnt<=0.
  - Back-to-back access: ready and a new mem_req in the following cycle re-enters MEM_WAIT via RUN.
- ERROR:
  - All writes=0, all flushes=0 (pipe frozen).
  - mem_timeout_err=1 until reset; inputs ignored.
- mem_ready without mem_req in RUN is ignored.
- Reset asserted mid-MEM_WAIT or mid-ERROR returns to INIT immediately and clears the error.

Optional Feature:
PIPE_HAZARD_PERF_EN.
- Defined: adds outputs stall_cycles[31:0] (RUN/MEM_WAIT cycles with pc_write=0), bubble_count[31:0] (load-use bubbles) and flush_count[31:0] (branch flushes).
  - All three counters reset to 0 and saturate at all-ones.
  - INIT and ERROR cycles are not counted.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - enum pipe_state_e {INIT, RUN, MEM_WAIT, ERROR} (2-bit);
  - REG_ADDR_W default constant;
  - struct stage_ctrl_s grouping the six strobes.
- One sub-module: hazard_detect, purely combinational load-use comparator (ex_MemRead, ex_rd, id_rs1, id_rs2, id_uses_rs2 -> load_use). Reused by the forwarding work.
- The FSM and counters stay in the top.

Test Plan:
- Reset release with INIT_CYCLES=4 -> flushes=1 and writes=0 for exactly 4 cycles; state_o=1 on cycle 5 with all writes=1.
- ex_MemRead=1, ex_rd=5, id_rs1=5 in RUN -> one cycle of pc_write=0, ifid_write=0, idex_flush=1. Repeat with ex_rd=0 -> no stall.
- branch_taken=1 together with a load-use match -> ifid_flush=idex_flush=1, pc_write=1, no stall cycle.
- mem_req=1 with mem_ready low for 3 cycles then high -> 3 frozen cycles (exmem_write=0, memwb_flush=1), state_o=2, return to RUN on the ready cycle.
- mem_req=1 with mem_ready never high, MEM_TIMEOUT=16 -> ERROR after 16 frozen cycles, mem_timeout_err=1 held; reset=0 clears it and re-enters INIT.
- With PIPE_HAZARD_PERF_EN: 2 load-use stalls + 1 branch + 3-cycle mem wait -> bubble_count=2, flush_count=1, stall_cycles=5.
